ysyx_22041412_axi_bridge: RTL and testbench

AXI4 master bridge that sits directly downstream of the data-memory stage's Dcache. It converts the Dcache's simple refill and writeback request/beat handshake into AXI4 AR/R and AW/W/B channel transactions. It supports single-beat uncached accesses and INCR bursts for cache-line transfers, with one outstanding transaction per direction.

---
 rtl/ysyx_22041412_axi_bridge_pkg.sv | 31 +++
 rtl/ysyx_22041412_axi_bridge_if.sv | 47 ++++
 rtl/ysyx_22041412_axi_strb_gen.sv | 20 ++
 rtl/ysyx_22041412_axi_bridge.sv | 160 ++++++++++++++++
 tb/tb_ysyx_22041412_axi_bridge.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22041412_axi_bridge_pkg.sv
// rtl/ysyx_22041412_axi_bridge_pkg.sv - shared FSM states, AXI constants and store strobe helper
package ysyx_22041412_axi_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } w_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;

  // Byte-lane mask of a store before it is shifted to its address offset.
  function automatic logic [7:0] size_mask(input logic [2:0] func3);
    case (func3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0f;
      default: size_mask = 8'hff;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22041412_axi_bridge_if.sv
// rtl/ysyx_22041412_axi_bridge_if.sv - AXI4 AR/R/AW/W/B channel bundle with master/slave views
interface ysyx_22041412_axi_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [3:0]              arid;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [3:0]              awid;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, rready,
    output awvalid, awaddr, awlen, awsize, awburst, awid,
    output wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
    input  awvalid, awaddr, awlen, awsize, awburst, awid,
    input  wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_22041412_axi_strb_gen.sv
// rtl/ysyx_22041412_axi_strb_gen.sv - awsize and wstrb for a write: full-width bursts, sized single beats
module ysyx_22041412_axi_strb_gen
  import ysyx_22041412_axi_bridge_pkg::*;
#(
  parameter int STRB_W = 8
) (
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [2:0]        offset,
  output logic [2:0]        awsize,
  output logic [STRB_W-1:0] strb
);
  logic       single;
  logic [7:0] shifted;

  assign single  = (len == 8'd0);
  assign shifted = size_mask(size) << offset;
  assign awsize  = single ? {1'b0, size[1:0]} : AXI_SIZE_8B;
  assign strb    = single ? STRB_W'(shifted) : {STRB_W{1'b1}};
endmodule

// File: rtl/ysyx_22041412_axi_bridge.sv
// rtl/ysyx_22041412_axi_bridge.sv - Dcache refill/writeback to AXI4 master; YSYX_22041412_AXI_RESP_CHECK_EN enables sticky axi_err_o
module ysyx_22041412_axi_bridge
  import ysyx_22041412_axi_bridge_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 64,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_valid_i,
  input  logic [ADDR_WIDTH-1:0] r_addr_i,
  input  logic [7:0]            r_len_i,
  output logic                  r_ready_o,
  output logic                  r_last_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  input  logic                  w_valid_i,
  input  logic [ADDR_WIDTH-1:0] w_addr_i,
  input  logic [7:0]            w_len_i,
  input  logic [2:0]            w_size_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  output logic                  w_ready_o,
  output logic                  w_last_o,
  output logic                  axi_err_o,
  ysyx_22041412_axi_bridge_if.master axi
);
  localparam int STRB_W = DATA_WIDTH / 8;

  r_state_e              r_state;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [7:0]            r_len_q;

  w_state_e              w_state;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            w_len_q;
  logic [2:0]            w_size_q;
  logic [7:0]            w_cnt;
  logic                  w_last_q;

  logic                  w_req_new;
  logic                  r_beat;
  logic                  w_beat;
  logic                  w_is_last;
  logic [2:0]            awsize_gen;
  logic [STRB_W-1:0]     strb_gen;

  // A write request still high while w_last_o pulses belongs to the finished transaction.
  assign w_req_new = w_valid_i && !w_last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= R_IDLE;
      r_addr_q <= '0;
      r_len_q  <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (r_valid_i && (w_state == W_IDLE) && !w_req_new) begin
          r_state  <= R_ADDR;
          r_addr_q <= r_addr_i;
          r_len_q  <= r_len_i;
        end
        R_ADDR: if (axi.arready) r_state <= R_DATA;
        R_DATA: if (axi.rvalid && axi.rlast) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state  <= W_IDLE;
      w_addr_q <= '0;
      w_len_q  <= '0;
      w_size_q <= '0;
      w_cnt    <= '0;
      w_last_q <= 1'b0;
    end else begin
      w_last_q <= 1'b0;
      case (w_state)
        W_IDLE: if (w_req_new) begin
          w_state  <= W_ADDR;
          w_addr_q <= w_addr_i;
          w_len_q  <= w_len_i;
          w_size_q <= w_size_i;
          w_cnt    <= '0;
        end
        W_ADDR: if (axi.awready) w_state <= W_DATA;
        W_DATA: if (axi.wready) begin
          if (w_is_last) w_state <= W_RESP;
          else           w_cnt   <= w_cnt + 8'd1;
        end
        W_RESP: if (axi.bvalid) begin
          w_state  <= W_IDLE;
          w_last_q <= 1'b1;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  ysyx_22041412_axi_strb_gen #(
    .STRB_W (STRB_W)
  ) u_strb_gen (
    .len    (w_len_q),
    .size   (w_size_q),
    .offset (w_addr_q[2:0]),
    .awsize (awsize_gen),
    .strb   (strb_gen)
  );

  assign axi.arvalid = (r_state == R_ADDR);
  assign axi.araddr  = r_addr_q;
  assign axi.arlen   = r_len_q;
  assign axi.arsize  = AXI_SIZE_8B;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arid    = AXI_ID;
  assign axi.rready  = (r_state == R_DATA);

  assign r_beat    = axi.rready && axi.rvalid;
  assign r_ready_o = r_beat;
  assign r_last_o  = r_beat && axi.rlast;
  assign r_data_o  = r_beat ? axi.rdata : '0;

  assign axi.awvalid = (w_state == W_ADDR);
  assign axi.awaddr  = w_addr_q;
  assign axi.awlen   = w_len_q;
  assign axi.awsize  = awsize_gen;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awid    = AXI_ID;

  // Write data passes straight through from the Dcache while a beat is offered.
  assign axi.wvalid = (w_state == W_DATA);
  assign w_is_last  = (w_cnt == w_len_q);
  assign axi.wlast  = axi.wvalid && w_is_last;
  assign axi.wdata  = axi.wvalid ? w_data_i : '0;
  assign axi.wstrb  = axi.wvalid ? strb_gen : '0;
  assign axi.bready = (w_state == W_RESP);

  assign w_beat    = axi.wvalid && axi.wready;
  assign w_ready_o = w_beat;
  assign w_last_o  = w_last_q;

`ifdef YSYX_22041412_AXI_RESP_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((r_beat && (axi.rresp != AXI_RESP_OKAY)) ||
                 (axi.bready && axi.bvalid && (axi.bresp != AXI_RESP_OKAY))) begin
      err_q <= 1'b1;
    end
  end

  assign axi_err_o = err_q;
`else
  assign axi_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22041412_axi_bridge.sv
// tb/tb_ysyx_22041412_axi_bridge.sv - directed self-checking bench for the Dcache AXI bridge
module tb_ysyx_22041412_axi_bridge;
  import ysyx_22041412_axi_bridge_pkg::*;

`ifdef YSYX_22041412_AXI_RESP_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        r_valid_i;
  logic [31:0] r_addr_i;
  logic [7:0]  r_len_i;
  logic        r_ready_o;
  logic        r_last_o;
  logic [63:0] r_data_o;
  logic        w_valid_i;
  logic [31:0] w_addr_i;
  logic [7:0]  w_len_i;
  logic [2:0]  w_size_i;
  logic [63:0] w_data_i;
  logic        w_ready_o;
  logic        w_last_o;
  logic        axi_err_o;

  int pass_cnt;
  int total_cnt;

  ysyx_22041412_axi_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) axi ();

  ysyx_22041412_axi_bridge #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (64),
    .AXI_ID     (4'd0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .r_valid_i (r_valid_i),
    .r_addr_i  (r_addr_i),
    .r_len_i   (r_len_i),
    .r_ready_o (r_ready_o),
    .r_last_o  (r_last_o),
    .r_data_o  (r_data_o),
    .w_valid_i (w_valid_i),
    .w_addr_i  (w_addr_i),
    .w_len_i   (w_len_i),
    .w_size_i  (w_size_i),
    .w_data_i  (w_data_i),
    .w_ready_o (w_ready_o),
    .w_last_o  (w_last_o),
    .axi_err_o (axi_err_o),
    .axi       (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    r_valid_i = 0; r_addr_i = '0; r_len_i = '0;
    w_valid_i = 0; w_addr_i = '0; w_len_i = '0; w_size_i = '0; w_data_i = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    total_cnt++; if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0)
      $display("FAIL reset_valids: got %b want 00000", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}); else pass_cnt++;
    total_cnt++; if ({r_ready_o, r_last_o, w_ready_o, w_last_o, axi_err_o} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {r_ready_o, r_last_o, w_ready_o, w_last_o, axi_err_o}); else pass_cnt++;
    total_cnt++; if ({r_data_o, axi.wdata, axi.araddr, axi.awaddr} !== '0)
      $display("FAIL reset_data: got %h want 0", {r_data_o, axi.wdata, axi.araddr, axi.awaddr}); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    total_cnt++; if (axi.arvalid !== 1'b0 || axi.awvalid !== 1'b0)
      $display("FAIL reset_idle: got ar=%b aw=%b want 0 0", axi.arvalid, axi.awvalid); else pass_cnt++;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    r_valid_i = 1; r_addr_i = 32'h8000_0010; r_len_i = 8'd0;
    #1;
    total_cnt++; if (axi.arvalid !== 1'b0) $display("FAIL sr_ar_early: got %b want 0", axi.arvalid); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (axi.arvalid !== 1'b1) $display("FAIL sr_arvalid: got %b want 1", axi.arvalid); else pass_cnt++;
    total_cnt++; if ({axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid} !== {32'h8000_0010, 8'd0, 3'b011, 2'b01, 4'd0})
      $display("FAIL sr_ar_fields: got %h %h %h %h %h want 80000010 00 3 1 0", axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid); else pass_cnt++;
    axi.arready = 1;
    @(negedge clk);
    axi.arready = 0;
    #1;
    total_cnt++; if ({axi.arvalid, axi.rready, r_ready_o} !== 3'b010)
      $display("FAIL sr_wait_data: got %b want 010", {axi.arvalid, axi.rready, r_ready_o}); else pass_cnt++;
    axi.rvalid = 1; axi.rdata = 64'h1122_3344_5566_7788; axi.rlast = 1;
    #1;
    total_cnt++; if ({r_ready_o, r_last_o} !== 2'b11 || r_data_o !== 64'h1122_3344_5566_7788)
      $display("FAIL sr_beat: got rdy=%b last=%b data=%h want 1 1 1122334455667788", r_ready_o, r_last_o, r_data_o); else pass_cnt++;
    @(negedge clk);
    axi.rvalid = 0; axi.rlast = 0; axi.rdata = '0; r_valid_i = 0;
    #1;
    total_cnt++; if ({axi.rready, r_ready_o, r_last_o} !== 3'b000)
      $display("FAIL sr_done: got %b want 000", {axi.rready, r_ready_o, r_last_o}); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (axi.arvalid !== 1'b0) $display("FAIL sr_no_reissue: got %b want 0", axi.arvalid); else pass_cnt++;
  endtask

  task automatic test_refill_gaps();
    int beat;
    bit done;
    beat = 0; done = 0;
    @(negedge clk);
    r_valid_i = 1; r_addr_i = 32'h8000_0040; r_len_i = 8'd3;
    @(negedge clk); #1;
    total_cnt++; if (axi.arvalid !== 1'b1 || axi.arlen !== 8'd3)
      $display("FAIL rf_ar: got valid=%b len=%h want 1 03", axi.arvalid, axi.arlen); else pass_cnt++;
    axi.arready = 1;
    @(negedge clk);
    axi.arready = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (done) r_valid_i = 0;
      axi.rvalid = !done && (k % 2 == 0);
      axi.rdata  = 64'hA000 + 64'(beat);
      axi.rlast  = (beat == 3);
      #1;
      if (r_ready_o) begin
        total_cnt++; if (r_data_o !== 64'hA000 + 64'(beat) || r_last_o !== (beat == 3))
          $display("FAIL rf_beat%0d: got data=%h last=%b want %h %b", beat, r_data_o, r_last_o, 64'hA000 + 64'(beat), (beat == 3)); else pass_cnt++;
        if (r_last_o) done = 1;
        beat++;
      end
    end
    axi.rvalid = 0; axi.rlast = 0; axi.rdata = '0;
    total_cnt++; if (beat !== 4) $display("FAIL rf_count: got %0d want 4", beat); else pass_cnt++;
  endtask

  task automatic test_store_byte();
    @(negedge clk);
    w_valid_i = 1; w_addr_i = 32'h8000_0005; w_len_i = 8'd0; w_size_i = 3'b000; w_data_i = 64'h0000_5500_0000_0000;
    @(negedge clk); #1;
    total_cnt++; if (axi.awvalid !== 1'b1 || axi.awsize !== 3'd0 || axi.awaddr !== 32'h8000_0005 || axi.awlen !== 8'd0)
      $display("FAIL sb_aw: got v=%b size=%0d addr=%h len=%h want 1 0 80000005 00", axi.awvalid, axi.awsize, axi.awaddr, axi.awlen); else pass_cnt++;
    axi.awready = 1;
    @(negedge clk);
    axi.awready = 0;
    #1;
    total_cnt++; if ({axi.wvalid, axi.wlast} !== 2'b11 || axi.wstrb !== 8'h20 || axi.wdata !== 64'h0000_5500_0000_0000)
      $display("FAIL sb_w: got v=%b last=%b strb=%h data=%h want 1 1 20 0000550000000000", axi.wvalid, axi.wlast, axi.wstrb, axi.wdata); else pass_cnt++;
    axi.wready = 1;
    #1;
    total_cnt++; if (w_ready_o !== 1'b1) $display("FAIL sb_wready: got %b want 1", w_ready_o); else pass_cnt++;
    @(negedge clk);
    axi.wready = 0;
    #1;
    total_cnt++; if ({axi.bready, w_last_o} !== 2'b10) $display("FAIL sb_resp_wait: got %b want 10", {axi.bready, w_last_o}); else pass_cnt++;
    axi.bvalid = 1; axi.bresp = 2'b00;
    @(negedge clk);
    axi.bvalid = 0;
    #1;
    total_cnt++; if (w_last_o !== 1'b1) $display("FAIL sb_wlast_pulse: got %b want 1", w_last_o); else pass_cnt++;
    @(negedge clk);
    w_valid_i = 0;
    #1;
    total_cnt++; if ({w_last_o, axi.awvalid} !== 2'b00) $display("FAIL sb_no_reissue: got %b want 00", {w_last_o, axi.awvalid}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int wbeat, rbeat, early_ar;
    bit wdone, rdone;
    wbeat = 0; rbeat = 0; early_ar = 0; wdone = 0; rdone = 0;
    @(negedge clk);
    w_valid_i = 1; w_addr_i = 32'h8000_0100; w_len_i = 8'd3; w_size_i = 3'b011;
    r_valid_i = 1; r_addr_i = 32'h8000_0200; r_len_i = 8'd3;
    for (int k = 0; k < 60 && !rdone; k++) begin
      if (k > 0) @(negedge clk);
      if (wdone) w_valid_i = 0;
      axi.awready = 1; axi.wready = 1; axi.arready = 1; axi.bvalid = 1; axi.bresp = 2'b00;
      axi.rvalid = 1; axi.rresp = 2'b00; axi.rlast = (rbeat == 3); axi.rdata = 64'hC0 + 64'(rbeat);
      w_data_i = 64'hB0 + 64'(wbeat);
      #1;
      if (axi.arvalid && !wdone) early_ar++;
      if (w_ready_o) begin
        total_cnt++; if (axi.wdata !== 64'hB0 + 64'(wbeat) || axi.wlast !== (wbeat == 3) || axi.wstrb !== 8'hff || axi.awsize !== 3'b011)
          $display("FAIL bb_wbeat%0d: got data=%h last=%b strb=%h size=%0d want %h %b ff 3", wbeat, axi.wdata, axi.wlast, axi.wstrb, axi.awsize, 64'hB0 + 64'(wbeat), (wbeat == 3)); else pass_cnt++;
        wbeat++;
      end
      if (w_last_o) wdone = 1;
      if (r_ready_o) begin
        total_cnt++; if (r_data_o !== 64'hC0 + 64'(rbeat) || r_last_o !== (rbeat == 3))
          $display("FAIL bb_rbeat%0d: got data=%h last=%b want %h %b", rbeat, r_data_o, r_last_o, 64'hC0 + 64'(rbeat), (rbeat == 3)); else pass_cnt++;
        if (r_last_o) rdone = 1;
        rbeat++;
      end
    end
    @(negedge clk);
    clear_inputs();
    total_cnt++; if (early_ar !== 0) $display("FAIL bb_order: got %0d early arvalid cycles want 0", early_ar); else pass_cnt++;
    total_cnt++; if (wbeat !== 4 || !wdone) $display("FAIL bb_write: got beats=%0d done=%b want 4 1", wbeat, wdone); else pass_cnt++;
    total_cnt++; if (rbeat !== 4 || !rdone) $display("FAIL bb_read: got beats=%0d done=%b want 4 1", rbeat, rdone); else pass_cnt++;
  endtask

  task automatic test_resp_err();
    @(negedge clk);
    w_valid_i = 1; w_addr_i = 32'h8000_0008; w_len_i = 8'd0; w_size_i = 3'b011; w_data_i = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    axi.awready = 1;
    @(negedge clk);
    axi.awready = 0; axi.wready = 1;
    #1;
    total_cnt++; if (axi.wstrb !== 8'hff || axi.awsize !== 3'b011 || w_ready_o !== 1'b1)
      $display("FAIL er_sd_beat: got strb=%h size=%0d rdy=%b want ff 3 1", axi.wstrb, axi.awsize, w_ready_o); else pass_cnt++;
    @(negedge clk);
    axi.wready = 0; axi.bvalid = 1; axi.bresp = 2'b10;
    @(negedge clk);
    axi.bvalid = 0; axi.bresp = 2'b00;
    #1;
    total_cnt++; if (w_last_o !== 1'b1 || axi_err_o !== ERR_EXP)
      $display("FAIL er_set: got last=%b err=%b want 1 %b", w_last_o, axi_err_o, ERR_EXP); else pass_cnt++;
    @(negedge clk);
    w_valid_i = 0;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++; if (axi_err_o !== ERR_EXP) $display("FAIL er_sticky: got %b want %b", axi_err_o, ERR_EXP); else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    int seen;
    seen = 0;
    @(negedge clk);
    r_valid_i = 1; r_addr_i = 32'h8000_0080; r_len_i = 8'd3;
    @(negedge clk);
    axi.arready = 1;
    @(negedge clk);
    axi.arready = 0;
    axi.rvalid = 1; axi.rlast = 0; axi.rdata = 64'hE0;
    @(negedge clk);
    axi.rdata = 64'hE1;
    @(negedge clk);
    axi.rdata = 64'hE2;
    #1;
    total_cnt++; if (r_ready_o !== 1'b1 || r_data_o !== 64'hE2)
      $display("FAIL mr_beat2: got rdy=%b data=%h want 1 e2", r_ready_o, r_data_o); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if ({r_ready_o, r_last_o, axi.rready, axi.arvalid} !== 4'b0 || r_data_o !== '0 || axi.araddr !== '0)
      $display("FAIL mr_async: got flags=%b data=%h addr=%h want 0000 0 0", {r_ready_o, r_last_o, axi.rready, axi.arvalid}, r_data_o, axi.araddr); else pass_cnt++;
    r_valid_i = 0; axi.rvalid = 0; axi.rdata = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      axi.rvalid = 1; axi.rlast = 1;
      #1;
      if (r_last_o || r_ready_o || axi.arvalid || axi.rready) seen++;
    end
    clear_inputs();
    total_cnt++; if (seen !== 0) $display("FAIL mr_idle: got %0d active cycles want 0", seen); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_single_read();
    test_refill_gaps();
    test_store_byte();
    test_back_to_back();
    test_resp_err();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
